// File: rtl/ram_dp_resp.sv
// Dual-port 4096x64 RAM responder: independent write/read ports, registered read with
// write-first collision bypass, written-since-reset bitmap. Optional parity: RAM_DP_RESP_PARITY_EN.
module ram_dp_resp #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic              write,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic              read,
`ifdef RAM_DP_RESP_PARITY_EN
  input  logic              err_inject,
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              rd_unwritten
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic [DATA_W-1:0] rd_word_c;
  logic              rd_unwritten_c;
  logic              collide_c;

  // Array storage; contents survive reset, the bitmap hides stale words.
  always_ff @(posedge clock) begin
    if (write) begin
      mem[wr_address] <= data_in;
    end
  end

`ifdef RAM_DP_RESP_PARITY_EN
  logic par_mem [DEPTH];
  logic parity_err_c;

  // Even parity of the written word, optionally corrupted for error injection.
  always_ff @(posedge clock) begin
    if (write) begin
      par_mem[wr_address] <= (^data_in) ^ err_inject;
    end
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      written <= '0;
    end else if (write) begin
      written[wr_address] <= 1'b1;
    end
  end

  assign collide_c = read && write && (rd_address == wr_address);

  // Read word selection: bypass first, then unwritten masking, then array.
  always_comb begin
    rd_word_c      = '0;
    rd_unwritten_c = 1'b0;
`ifdef RAM_DP_RESP_PARITY_EN
    parity_err_c   = 1'b0;
`endif
    if (collide_c) begin
      rd_word_c = data_in;
    end else if (!written[rd_address]) begin
      rd_unwritten_c = 1'b1;
    end else begin
      rd_word_c = mem[rd_address];
`ifdef RAM_DP_RESP_PARITY_EN
      parity_err_c = (^mem[rd_address]) != par_mem[rd_address];
`endif
    end
  end

  // Registered read result; data_out holds across idle cycles.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out     <= '0;
      rd_valid     <= 1'b0;
      rd_unwritten <= 1'b0;
`ifdef RAM_DP_RESP_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else if (read) begin
      data_out     <= rd_word_c;
      rd_valid     <= 1'b1;
      rd_unwritten <= rd_unwritten_c;
`ifdef RAM_DP_RESP_PARITY_EN
      parity_err   <= parity_err_c;
`endif
    end else begin
      rd_valid     <= 1'b0;
      rd_unwritten <= 1'b0;
`ifdef RAM_DP_RESP_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end
  end

endmodule

// File: doc/ram_dp_resp.md
Name: ram_dp_resp

Overview:
- Synthesizable dual-port 4096x64 RAM. It is the responder that the write and read BFMs drive, and that the write and read monitors observe.
- Independent write port and read port, both on one clock.
- Registered read, with write-first bypass on address collision.
- A per-word written-since-reset bitmap, so stale contents are never returned after reset.

Parameters:
- DATA_W, 64, word width in bits.
- ADDR_W, 12, address width; depth = 2**ADDR_W = 4096.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- resetn  input  1  asynchronous active-low reset.
- data_in  input  DATA_W  write data.
- wr_address  input  ADDR_W  write address.
- write  input  1  write enable, sampled at posedge.
- rd_address  input  ADDR_W  read address.
- read  input  1  read enable, sampled at posedge.
- data_out  output  DATA_W  registered read data.
- rd_valid  output  1  high for exactly one cycle when data_out carries a new read result.
- rd_unwritten  output  1  qualifies rd_valid; the addressed word has not been written since reset.

Behaviour:
- Reset (resetn low, asynchronous assert, synchronous release at next posedge):
  - data_out = 0, rd_valid = 0, rd_unwritten = 0.
  - Written-bitmap cleared to all 0.
  - Memory array is NOT cleared.
- Write: at a posedge with write=1, mem[wr_address] <= data_in and written[wr_address] <= 1. Write is a single cycle with no backpressure.
- Read latency is 1 cycle. At a posedge with read=1, then after that edge:
  - data_out = word, rd_valid = 1.
  - rd_unwritten = ~written[rd_address], evaluated with the bypass below.
- Read data selection:
  - Word has never been written: data_out = 0 and rd_unwritten = 1. The stored array value is ignored.
  - Collision (read=1 and write=1 in the same cycle, rd_address == wr_address): write-first. data_out = data_in of that cycle, rd_unwritten = 0.
  - Different addresses in the same cycle: fully independent.
- read=0 at a posedge: rd_valid = 0, rd_unwritten = 0, and data_out holds its last value.
- Back-to-back reads every cycle: one result per cycle, in order.
- Address wrap: addresses are exactly ADDR_W bits, so there is no out-of-range case. Address 4095 and address 0 are ordinary entries.
- Reset mid-operation: a read issued in the cycle before resetn falls is discarded (rd_valid forced 0). Writes in flight at reset are lost.
- X-safety: while write=0, data_in is don't-care; while read=0, rd_address is don't-care. Neither may change any state.

Optional Feature:
- Macro: RAM_DP_RESP_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from data_in on write.
  - Added input err_inject (1 bit): when high during a write, the stored parity bit is inverted.
  - Added output parity_err (1 bit): registered and aligned with rd_valid; it is 1 when the read word's recomputed parity mismatches the stored bit.
  - parity_err is forced 0 for unwritten words and for bypassed collision reads.
  - parity_err resets to 0.
- Not defined: no parity storage, and neither err_inject nor parity_err exists.

Test Plan:
- Reset then read addr 0x123 with no prior write -> next cycle rd_valid=1, rd_unwritten=1, data_out=0.
- Write 0xDEADBEEF_CAFEF00D to 0x000, then 0x0123456789ABCDEF to 0xFFF; read 0x000 then 0xFFF on consecutive cycles -> results arrive in order, 1 cycle each, rd_unwritten=0.
- Same-cycle write 0xA5A5A5A5A5A5A5A5 and read of addr 0x055 -> next cycle data_out=0xA5A5A5A5A5A5A5A5, rd_unwritten=0. Same stimulus with read addr 0x056 (unwritten) -> data_out=0, rd_unwritten=1.
- Write 0x1111 to addr 0x010, pulse resetn low for 2 cycles, read 0x010 -> data_out=0, rd_unwritten=1. Rewrite 0x2222 and read -> 0x2222.
- read=0 for 5 cycles after reading 0x1111 -> rd_valid=0 throughout, data_out stays 0x1111.
- With RAM_DP_RESP_PARITY_EN: write 0x7 to 0x020 with err_inject=1, read 0x020 -> parity_err=1, data_out=0x7. Write 0x7 to 0x021 with err_inject=0, read 0x021 -> parity_err=0.
